// File: rtl/log_fpmul_pkg.sv
// Shared types, size helpers and special-value builders for the serial
// logarithmic (Mitchell) floating-point multiplier.
package log_fpmul_pkg;

    // Top-level sequencing: gather operands, compute once, stream result out.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_e;

    // Operand classification used by the special-value precedence logic.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // Widest float word the builder functions can describe.
    localparam int MAX_WORD_W = 64;

    function automatic int f_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int f_nslice(input int word_w, input int bus_w);
        return (word_w + bus_w - 1) / bus_w;
    endfunction

    function automatic int f_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
    function automatic logic [MAX_WORD_W-1:0] f_canon_nan(input int exp_w, input int man_w);
        logic [MAX_WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < exp_w; i++) begin
            w[man_w + i] = 1'b1;
        end
        w[man_w - 1] = 1'b1;
        return w;
    endfunction

    // Infinity with the requested sign: exponent all ones, mantissa zero.
    function automatic logic [MAX_WORD_W-1:0] f_signed_inf(input logic sign, input int exp_w,
                                                           input int man_w);
        logic [MAX_WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < exp_w; i++) begin
            w[man_w + i] = 1'b1;
        end
        w[exp_w + man_w] = sign;
        return w;
    endfunction

endpackage

// File: rtl/log_fpmul_core.sv
// Combinational Mitchell multiplier: classify both operands, add the raw
// encodings minus the bias, then saturate to inf or flush to zero.
module log_fpmul_core
    import log_fpmul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] a_i,
    input  logic [EXP_W+MAN_W:0] b_i,
    output logic [EXP_W+MAN_W:0] res_o
);

    localparam int WORD_W = f_word_w(EXP_W, MAN_W);
    localparam int SUM_W  = EXP_W + MAN_W + 2;
    localparam int BIAS   = f_bias(EXP_W);
    localparam logic [SUM_W-1:0]      BIAS_SH = SUM_W'(BIAS) << MAN_W;
    localparam logic [EXP_W+1:0]      EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [MAX_WORD_W-1:0] NAN_W   = f_canon_nan(EXP_W, MAN_W);
    localparam logic [MAX_WORD_W-1:0] INF_W   = f_signed_inf(1'b0, EXP_W, MAN_W);

    logic             sa, sb, sign;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    fp_class_e        cls_a, cls_b;
    logic [SUM_W-1:0] sum;
    logic [EXP_W+1:0] s_exp;
    logic             any_nan, any_inf, any_zero;
    logic [WORD_W-1:0] inf_res, zero_res;

    function automatic fp_class_e f_classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        fp_class_e c;
        if (e == '0) begin
            c = CLS_ZERO;               // subnormals are flushed
        end else if (&e) begin
            c = (m == '0) ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    assign {sa, ea, ma} = a_i;
    assign {sb, eb, mb} = b_i;
    assign sign  = sa ^ sb;
    assign cls_a = f_classify(ea, ma);
    assign cls_b = f_classify(eb, mb);

    // Two spare top bits keep the sum from wrapping: the MSB acts as a sign.
    assign sum   = {2'b00, ea, ma} + {2'b00, eb, mb} - BIAS_SH;
    assign s_exp = sum[SUM_W-1:MAN_W];

    assign any_nan  = (cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
                      ((cls_a == CLS_INF) && (cls_b == CLS_ZERO)) ||
                      ((cls_b == CLS_INF) && (cls_a == CLS_ZERO));
    assign any_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
    assign any_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);

    assign inf_res  = {sign, INF_W[WORD_W-2:0]};
    assign zero_res = {sign, {(WORD_W-1){1'b0}}};

    // Special-value precedence first, then range check of the Mitchell sum.
    always_comb begin
        res_o = {sign, sum[EXP_W+MAN_W-1:0]};
        if (any_nan) begin
            res_o = NAN_W[WORD_W-1:0];
        end else if (any_inf) begin
            res_o = inf_res;
        end else if (any_zero) begin
            res_o = zero_res;
        end else if (s_exp[EXP_W+1]) begin
            res_o = zero_res;           // negative sum: underflow
        end else if (s_exp >= EXP_MAX) begin
            res_o = inf_res;            // exponent overflow saturates
        end else if (s_exp == '0) begin
            res_o = zero_res;
        end
    end

endmodule

// File: rtl/log_fpmul_serial.sv
// Slice-serial wrapper: assembles A/B from BUS_W-bit slices, computes the
// approximate product in one cycle and streams it back LSB slice first.
module log_fpmul_serial
    import log_fpmul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [BUS_W-1:0] a_slice,
    input  logic [BUS_W-1:0] b_slice,
    output logic [BUS_W-1:0] out_slice,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    localparam int WORD_W = f_word_w(EXP_W, MAN_W);
    localparam int NSLICE = f_nslice(WORD_W, BUS_W);
    localparam int BUF_W  = NSLICE * BUS_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] a_q, a_d, b_q, b_d;
    logic [BUF_W-1:0]  res_q, res_d;
    logic [BUS_W-1:0]  out_slice_q, out_slice_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [WORD_W-1:0] core_res;

    log_fpmul_core #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_core (
        .a_i  (a_q),
        .b_i  (b_q),
        .res_o(core_res)
    );

    // State and datapath registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_slice_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            out_slice_q <= out_slice_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic: slice assembly, one-cycle compute, shift-out.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        out_slice_d = out_slice_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (ena) begin
            if (clr) begin
                state_d     = LOAD;
                cnt_d       = '0;
                out_slice_d = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                case (state_q)
                    LOAD: begin
                        out_slice_d = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (in_valid) begin
                            // Bits beyond WORD_W in the top slice are dropped.
                            for (int i = 0; i < NSLICE; i++) begin
                                if (cnt_q == CNT_W'(i)) begin
                                    for (int k = 0; k < BUS_W; k++) begin
                                        if (i * BUS_W + k < WORD_W) begin
                                            a_d[i*BUS_W+k] = a_slice[k];
                                            b_d[i*BUS_W+k] = b_slice[k];
                                        end
                                    end
                                end
                            end
                            if (cnt_q == CNT_LAST) begin
                                cnt_d   = '0;
                                state_d = CALC;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    CALC: begin
                        res_d   = BUF_W'(core_res);
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                    SEND: begin
                        out_slice_d = res_q[BUS_W-1:0];
                        out_valid_d = 1'b1;
                        out_last_d  = (cnt_q == CNT_LAST);
                        res_d       = res_q >> BUS_W;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = LOAD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign out_slice = out_slice_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != LOAD);

endmodule

// File: tb/tb_log_fpmul_serial.sv
// Directed bench for the serial Mitchell multiplier: FP16 default instance
// plus an FP32 instance, with hand-computed expected results.
module tb_log_fpmul_serial;

    logic       clk = 1'b0;
    logic       rst_n, ena, clr;
    logic       in_valid;
    logic [7:0] a_slice, b_slice, out_slice;
    logic       out_valid, out_last, busy;
    logic       in_valid32;
    logic [7:0] a32_slice, b32_slice, out32_slice;
    logic       out32_valid, out32_last, busy32;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    log_fpmul_serial dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid),
        .a_slice(a_slice), .b_slice(b_slice), .out_slice(out_slice),
        .out_valid(out_valid), .out_last(out_last), .busy(busy)
    );

    log_fpmul_serial #(.EXP_W(8), .MAN_W(23), .BUS_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid32),
        .a_slice(a32_slice), .b_slice(b32_slice), .out_slice(out32_slice),
        .out_valid(out32_valid), .out_last(out32_last), .busy(busy32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive both FP16 slices; returns just after the edge accepting slice 1.
    task automatic load16(input logic [15:0] a, input logic [15:0] b, input int gap);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_slice  = a[i*8 +: 8];
            b_slice  = b[i*8 +: 8];
            step();
            in_valid = 1'b0;
            a_slice  = 8'hA5;
            b_slice  = 8'h5A;
            if (i == 0) repeat (gap) step();
        end
    endtask

    // Checks fixed latency, both slices, last flags and return to idle.
    task automatic expect16(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        logic [1:0]  lasts;
        chk({tag, "_v_e0"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_v_e1"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_v_s0"}, 32'(out_valid), 32'd1);
        got[7:0] = out_slice;
        lasts[0] = out_last;
        step();
        chk({tag, "_v_s1"}, 32'(out_valid), 32'd1);
        got[15:8] = out_slice;
        lasts[1]  = out_last;
        step();
        chk({tag, "_v_end"}, 32'(out_valid), 32'd0);
        chk({tag, "_sl_end"}, 32'(out_slice), 32'd0);
        chk({tag, "_word"}, 32'(got), 32'(exp));
        chk({tag, "_last"}, 32'(lasts), 32'd2);
        $display("op %s: result 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp);
        load16(a, b, 0);
        expect16(tag, exp);
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        logic [31:0] got;
        logic [3:0]  lasts;
        int          k;
        for (int i = 0; i < 4; i++) begin
            in_valid32 = 1'b1;
            a32_slice  = a[i*8 +: 8];
            b32_slice  = b[i*8 +: 8];
            step();
        end
        in_valid32 = 1'b0;
        k = 0;
        while (!out32_valid && k < 10) begin
            step();
            k++;
        end
        chk({tag, "_seen"}, 32'(out32_valid), 32'd1);
        chk({tag, "_lat"}, 32'(k), 32'd2);
        got   = '0;
        lasts = '0;
        for (int j = 0; j < 4; j++) begin
            got[j*8 +: 8] = out32_slice;
            lasts[j]      = out32_last;
            step();
        end
        chk({tag, "_word"}, got, exp);
        chk({tag, "_last"}, 32'(lasts), 32'h8);
        chk({tag, "_v_end"}, 32'(out32_valid), 32'd0);
        $display("op %s: result 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    initial begin
        rst_n = 1'b1; ena = 1'b1; clr = 1'b0;
        in_valid = 1'b0; a_slice = '0; b_slice = '0;
        in_valid32 = 1'b0; a32_slice = '0; b32_slice = '0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_slice", 32'(out_slice), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Main function and special values.
        run16("mul_1p5x3", 16'h3E00, 16'h4200, 16'h4400);
        run16("mul_1xm2", 16'h3C00, 16'hC000, 16'hC000);
        run16("ovf_sat", 16'h7800, 16'h7800, 16'h7C00);
        run16("unf_flush", 16'h0400, 16'h0400, 16'h0000);
        run16("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00);
        run16("inf_x_neg", 16'h7C00, 16'hBC00, 16'hFC00);
        run16("nan_in", 16'h7C01, 16'h3C00, 16'h7E00);
        run16("subnorm", 16'h0001, 16'h3C00, 16'h0000);

        // Input gap, stray in_valid while busy, and a 2-cycle freeze in SEND.
        load16(16'h3C01, 16'h3C02, 3);
        in_valid = 1'b1; a_slice = 8'hFF; b_slice = 8'hFF;
        chk("frz_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("frz_s0", 32'(out_slice), 32'h03);
        chk("frz_v0", 32'(out_valid), 32'd1);
        ena = 1'b0;
        repeat (2) begin
            step();
            chk("frz_hold_sl", 32'(out_slice), 32'h03);
            chk("frz_hold_v", 32'(out_valid), 32'd1);
            chk("frz_hold_l", 32'(out_last), 32'd0);
        end
        ena = 1'b1;
        in_valid = 1'b0;
        step();
        chk("frz_s1", 32'(out_slice), 32'h3C);
        chk("frz_l1", 32'(out_last), 32'd1);
        step();
        chk("frz_end", 32'(out_valid), 32'd0);
        $display("op freeze: 0x3C01 x 0x3C02 streamed with gap and freeze");
        run16("after_frz", 16'h3E00, 16'h4200, 16'h4400);

        // clr after the first slice discards it.
        in_valid = 1'b1; a_slice = 8'h77; b_slice = 8'h66;
        step();
        in_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        run16("after_clr", 16'h3C00, 16'hC000, 16'hC000);

        // Asynchronous reset in the middle of SEND.
        load16(16'h3E00, 16'h4200, 0);
        step();
        step();
        chk("prerst_v", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_slice", 32'(out_slice), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        step();
        run16("after_rst", 16'h7C00, 16'hBC00, 16'hFC00);

        // FP32 instance, four slices each way.
        run32("fp32_1p5x3", 32'h3FC00000, 32'h40400000, 32'h40800000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/log_fpmul_serial.md
Name: log_fpmul_serial

Overview:
Parametrised successor to the byte-serial logarithmic (Mitchell) approximate floating-point multiplier tile.
- Operands A and B arrive in parallel, one BUS_W-bit slice per cycle each, least-significant slice first.
- The block computes an approximate product by adding the raw encodings and removing the bias, and handles special values.
- The result leaves serially, slice by slice, with a valid/last strobe.
- The block sits directly behind the tile I/O pins: ui_in carries A, uio_in carries B, uo_out carries the result.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, mantissa field width (default is FP16)
BUS_W, 8, slice width per transfer
Derived: WORD_W = 1+EXP_W+MAN_W; NSLICE = ceil(WORD_W/BUS_W); BIAS = 2^(EXP_W-1)-1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous, active-low
ena  in  1  global enable; when low, all state holds
clr  in  1  synchronous flush back to LOAD
in_valid  in  1  a_slice/b_slice valid this cycle
a_slice  in  BUS_W  operand A slice
b_slice  in  BUS_W  operand B slice
out_slice  out  BUS_W  result slice, registered
out_valid  out  1  out_slice valid
out_last  out  1  final slice of the result
busy  out  1  high in CALC and SEND; input is ignored

Behaviour:
- Reset (async, rst_n=0): state=LOAD, slice count=0, operand registers=0, out_slice=0, out_valid=0, out_last=0, busy=0.
- Asserting rst_n low mid-operation aborts immediately. Partial operands are discarded.
- FSM states: LOAD, CALC, SEND. Every transition is gated by ena=1.
- LOAD:
  - When in_valid=1, slice i (i = 0..NSLICE-1) is stored into bits [i*BUS_W +: BUS_W] of A and B, and the count increments.
  - Gaps with in_valid=0 are allowed; the count holds.
  - Bits above WORD_W in the final slice are ignored.
  - On acceptance of slice NSLICE-1, go to CALC.
- CALC (1 cycle): the result word is computed and registered; go to SEND. busy=1.
- SEND (NSLICE cycles): out_valid=1; out_slice = result slice j, LSB slice first. out_last=1 on j=NSLICE-1; then go to LOAD with count=0.
- Latency: the first out_valid cycle begins 2 clk edges after the edge that accepted the final input slice.
- out_slice is 0 whenever out_valid=0.
- in_valid is ignored during CALC and SEND (no back-pressure; the source watches busy).
- ena=0: FSM, counters and outputs all freeze. out_valid stays at its current value.
- clr=1 with ena=1: go to LOAD, count=0, out_valid=0. clr has priority over in_valid and over any state transition.
- Arithmetic:
  - sign = sa^sb.
  - Classify each operand:
    - zero: e=0, including subnormals (flushed)
    - inf: e=all-ones, m=0
    - NaN: e=all-ones, m≠0
    - normal: otherwise
  - Precedence:
    1. Any NaN, or inf×zero -> canonical NaN: sign 0, e=all-ones, m MSB=1, other bits 0.
    2. Any inf -> signed inf.
    3. Any zero -> signed zero.
    4. Otherwise, Mitchell: S = {ea,ma} + {eb,mb} - (BIAS<<MAN_W), computed in EXP_W+MAN_W+2 signed bits. A mantissa carry naturally increments the exponent.
  - If the exponent field of S is >= all-ones -> signed inf (saturate).
  - If the exponent field is <= 0 (S negative or exponent 0) -> signed zero.
  - Otherwise the result is {sign, S[EXP_W+MAN_W-1:0]}.
  - No rounding; the result is deterministic, bit-exact to this formula.

Decomposition:
- Package log_fpmul_pkg holds:
  - state enum {LOAD, CALC, SEND}
  - functions for WORD_W/NSLICE/BIAS from the parameters
  - class encoding constants (ZERO, NORM, INF, NAN)
  - canonical-NaN and signed-inf builder functions
- One sub-module, log_fpmul_core: purely combinational classify + Mitchell add + saturate/flush, parametrised by EXP_W and MAN_W. The top holds the FSM, counters and the shift/assembly registers.

Test Plan:
- Defaults; A=0x3E00 (1.5), B=0x4200 (3.0); slices 0x00/0x00 then 0x3E/0x42 -> out_slice 0x00 then 0x44 (0x4400 = 4.0); out_last on the second slice; first out_valid 2 edges after the last input.
- A=0x3C00, B=0xC000 (1.0 × -2.0) -> 0xC000; A=0x7800, B=0x7800 -> 0x7C00 (overflow saturate); A=0x0400, B=0x0400 -> 0x0000 (underflow flush).
- A=0x7C00, B=0x0000 -> 0x7E00; A=0x7C00, B=0xBC00 -> 0xFC00; A=0x7C01, B=0x3C00 -> 0x7E00; A=0x0001 (subnormal), B=0x3C00 -> 0x0000.
- in_valid gap of 3 cycles between slices, plus ena=0 for 2 cycles in SEND -> same result, out_slice held during freeze, no slice lost or repeated; in_valid during CALC/SEND does not alter the result.
- clr asserted after slice 0; and rst_n pulsed low asynchronously mid-SEND -> all outputs 0 immediately; the next full operand pair produces the correct result.
- EXP_W=8, MAN_W=23, BUS_W=8 (FP32, NSLICE=4): 0x3FC00000 × 0x40400000 -> 0x40800000 over 4 slices, LSB first.
